aes_mm_host_sequencer: RTL and testbench

//   Bus-master counterpart of the AES memory-mapped register slave. Takes 128-bit
//   key/plaintext commands on a valid/ready stream and drives the slave's bus:

---
 rtl/aes_mm_pkg.sv | 60 ++++++
 rtl/aes_mm_host_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_aes_mm_host_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mm_pkg.sv
// Shared definitions for the AES memory-mapped slave and its host sequencer:
// bus register map, sequencer FSM states and 128-bit block <-> 32-bit word helpers.
package aes_mm_pkg;

    localparam logic [3:0] ADDR_IN0       = 4'd0;
    localparam logic [3:0] ADDR_IN1       = 4'd1;
    localparam logic [3:0] ADDR_IN2       = 4'd2;
    localparam logic [3:0] ADDR_IN3       = 4'd3;
    localparam logic [3:0] ADDR_LOAD_DATA = 4'd4;
    localparam logic [3:0] ADDR_LOAD_KEY  = 4'd5;
    localparam logic [3:0] ADDR_CT0       = 4'd6;
    localparam logic [3:0] ADDR_CT1       = 4'd7;
    localparam logic [3:0] ADDR_CT2       = 4'd8;
    localparam logic [3:0] ADDR_CT3       = 4'd9;
    localparam logic [3:0] ADDR_STATUS    = 4'd10;
    localparam logic [3:0] ADDR_ECHO0     = 4'd11;
    localparam logic [3:0] ADDR_ECHO1     = 4'd12;
    localparam logic [3:0] ADDR_ECHO2     = 4'd13;
    localparam logic [3:0] ADDR_ECHO3     = 4'd14;

    localparam int POLL_CNT_W = 9;

    typedef enum logic [3:0] {
        IDLE,
        WR,
        GO,
        WAIT,
        POLL,
        PCAP,
        RD,
        RCAP,
        RES
    } seqState_e;

    // Word 0 lives in the most significant 32 bits of a block.
    function automatic logic [31:0] blockWord(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] setBlockWord(input logic [127:0] blk, input logic [1:0] idx,
                                                  input logic [31:0] word);
        logic [127:0] r;
        r = blk;
        case (idx)
            2'd0:    r[127:96] = word;
            2'd1:    r[95:64]  = word;
            2'd2:    r[63:32]  = word;
            default: r[31:0]   = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_mm_host_sequencer.sv
// Bus master for the AES memory-mapped slave: turns key/plaintext stream
// commands into register writes, load strobes, status polls and ciphertext reads.
//
//   state | meaning
//   IDLE  | ready for a command, bus idle
//   WR    | write input words 0..3 to addresses 0..3
//   GO    | write the load-key or load-data strobe register
//   WAIT  | fixed CT_WAIT cycle wait for the core to finish
//   POLL  | read the status register
//   PCAP  | sample status bit 0 (done / repoll / time out)
//   RD    | read one ciphertext word
//   RCAP  | capture the word read in the previous cycle
//   RES   | present ciphertext until the consumer takes it
//
// The slave's status bit stays set once the first ciphertext exists, so it only
// gates the first block after reset; CT_WAIT is what guarantees completion.
module aes_mm_host_sequencer #(
    parameter int CT_WAIT  = 16,
    parameter int POLL_MAX = 256
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iCmdValid,
    output logic          oCmdReady,
    input  logic          iCmdIsKey,
    input  logic [127:0]  iCmdData,
    output logic          oResValid,
    input  logic          iResReady,
    output logic [127:0]  oResData,
    output logic          oTimeoutErr,
    output logic          oBusy,
    output logic          oChipSelect_n,
    output logic          oWrite_n,
    output logic          oRead_n,
    output logic [3:0]    oAddress,
    output logic [31:0]   oWrData,
    input  logic [31:0]   iRdData
);
    import aes_mm_pkg::*;

    localparam int WAIT_W = (CT_WAIT > 1) ? $clog2(CT_WAIT) : 1;

    seqState_e              state, stateNext;
    logic [1:0]             idx, idxNext;
    logic [WAIT_W-1:0]      waitCnt, waitCntNext;
    logic [POLL_CNT_W-1:0]  pollCnt, pollCntNext;
    logic [127:0]           cmdBlock, cmdBlockNext;
    logic                   cmdIsKey, cmdIsKeyNext;
    logic [127:0]           resBlock, resBlockNext;
    logic                   timeoutNext;
    logic                   chipSelNext_n, writeNext_n, readNext_n;
    logic [3:0]             addrNext;
    logic [31:0]            wrDataNext;
    logic                   cmdAccept;

    assign cmdAccept = iCmdValid && oCmdReady && (state == IDLE);
    assign oBusy     = (state != IDLE);
    assign oResData  = resBlock;

    // Next-state, counters and datapath registers.
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        waitCntNext  = waitCnt;
        pollCntNext  = pollCnt;
        cmdBlockNext = cmdBlock;
        cmdIsKeyNext = cmdIsKey;
        resBlockNext = resBlock;
        timeoutNext  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmdAccept) begin
                    cmdBlockNext = iCmdData;
                    cmdIsKeyNext = iCmdIsKey;
                    idxNext      = 2'd0;
                    stateNext    = WR;
                end
            end
            WR: begin
                idxNext = idx + 2'd1;
                if (idx == 2'd3) stateNext = GO;
            end
            GO: begin
                if (cmdIsKey) begin
                    stateNext = IDLE;
                end else begin
                    stateNext   = WAIT;
                    waitCntNext = WAIT_W'(CT_WAIT - 1);
                    pollCntNext = '0;
                end
            end
            WAIT: begin
                if (waitCnt == '0) stateNext = POLL;
                else               waitCntNext = waitCnt - 1'b1;
            end
            POLL: begin
                stateNext = PCAP;
                if (pollCnt != '1) pollCntNext = pollCnt + 1'b1;
            end
            PCAP: begin
                if (iRdData[0]) begin
                    stateNext = RD;
                    idxNext   = 2'd0;
                end else if (pollCnt == POLL_CNT_W'(POLL_MAX)) begin
                    stateNext   = IDLE;
                    timeoutNext = 1'b1;
                end else begin
                    stateNext = POLL;
                end
            end
            RD: stateNext = RCAP;
            RCAP: begin
                resBlockNext = setBlockWord(resBlock, idx, iRdData);
                idxNext      = idx + 2'd1;
                stateNext    = (idx == 2'd3) ? RES : RD;
            end
            RES: begin
                if (iResReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered strobes line up with the state.
    always_comb begin
        chipSelNext_n = 1'b1;
        writeNext_n   = 1'b1;
        readNext_n    = 1'b1;
        addrNext      = 4'd0;
        wrDataNext    = 32'd0;
        unique case (stateNext)
            WR: begin
                chipSelNext_n = 1'b0;
                writeNext_n   = 1'b0;
                addrNext      = ADDR_IN0 + {2'b00, idxNext};
                wrDataNext    = blockWord(cmdBlockNext, idxNext);
            end
            GO: begin
                chipSelNext_n = 1'b0;
                writeNext_n   = 1'b0;
                addrNext      = cmdIsKeyNext ? ADDR_LOAD_KEY : ADDR_LOAD_DATA;
            end
            POLL: begin
                chipSelNext_n = 1'b0;
                readNext_n    = 1'b0;
                addrNext      = ADDR_STATUS;
            end
            RD: begin
                chipSelNext_n = 1'b0;
                readNext_n    = 1'b0;
                addrNext      = ADDR_CT0 + {2'b00, idxNext};
            end
            default: ;
        endcase
    end

    // State, datapath and registered output update; reset aborts any transfer at once.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state         <= IDLE;
            idx           <= 2'd0;
            waitCnt       <= '0;
            pollCnt       <= '0;
            cmdBlock      <= '0;
            cmdIsKey      <= 1'b0;
            resBlock      <= '0;
            oCmdReady     <= 1'b0;
            oResValid     <= 1'b0;
            oTimeoutErr   <= 1'b0;
            oChipSelect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= 4'd0;
            oWrData       <= 32'd0;
        end else begin
            state         <= stateNext;
            idx           <= idxNext;
            waitCnt       <= waitCntNext;
            pollCnt       <= pollCntNext;
            cmdBlock      <= cmdBlockNext;
            cmdIsKey      <= cmdIsKeyNext;
            resBlock      <= resBlockNext;
            oCmdReady     <= (stateNext == IDLE);
            oResValid     <= (stateNext == RES);
            oTimeoutErr   <= timeoutNext;
            oChipSelect_n <= chipSelNext_n;
            oWrite_n      <= writeNext_n;
            oRead_n       <= readNext_n;
            oAddress      <= addrNext;
            oWrData       <= wrDataNext;
        end
    end

endmodule

// File: tb/tb_aes_mm_host_sequencer.sv
// Bench for the AES host sequencer: behavioural slave, bus monitor, result scoreboard.
module tb_aes_mm_host_sequencer;
    import aes_mm_pkg::*;

    localparam int CT_WAIT   = 16;
    localparam int POLL_MAX  = 4;
    localparam int SLAVE_LAT = 10;

    logic          iClk;
    logic          iReset;
    logic          iCmdValid;
    logic          oCmdReady;
    logic          iCmdIsKey;
    logic [127:0]  iCmdData;
    logic          oResValid;
    logic          iResReady;
    logic [127:0]  oResData;
    logic          oTimeoutErr;
    logic          oBusy;
    logic          oChipSelect_n;
    logic          oWrite_n;
    logic          oRead_n;
    logic [3:0]    oAddress;
    logic [31:0]   oWrData;
    logic [31:0]   iRdData;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    aes_mm_host_sequencer #(.CT_WAIT(CT_WAIT), .POLL_MAX(POLL_MAX)) dut (
        .iClk(iClk), .iReset(iReset),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdIsKey(iCmdIsKey), .iCmdData(iCmdData),
        .oResValid(oResValid), .iResReady(iResReady), .oResData(oResData),
        .oTimeoutErr(oTimeoutErr), .oBusy(oBusy),
        .oChipSelect_n(oChipSelect_n), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
        .oAddress(oAddress), .oWrData(oWrData), .iRdData(iRdData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    // Stand-in for the AES core: any word-order or capture error changes the result.
    function automatic logic [127:0] cipherModel(input logic [127:0] k, input logic [127:0] p);
        return {p[95:0], p[127:96]} ^ k ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    // ---------------- behavioural slave ----------------
    logic [31:0]  slvIn [4];
    logic [127:0] slvKey = '0;
    logic [127:0] slvPt = '0;
    logic [127:0] slvCt = '0;
    logic         slvStatus = 1'b0;
    int           slvCnt = 0;
    logic         stuckStatus = 1'b0;

    always @(posedge iClk) begin
        if (slvCnt != 0) slvCnt <= slvCnt - 1;
        if (slvCnt == 1) begin
            slvCt     <= cipherModel(slvKey, slvPt);
            slvStatus <= 1'b1;
        end
        if (!oChipSelect_n && !oWrite_n) begin
            if (oAddress <= ADDR_IN3) slvIn[oAddress[1:0]] <= oWrData;
            else if (oAddress == ADDR_LOAD_KEY) slvKey <= {slvIn[0], slvIn[1], slvIn[2], slvIn[3]};
            else if (oAddress == ADDR_LOAD_DATA) begin
                slvPt  <= {slvIn[0], slvIn[1], slvIn[2], slvIn[3]};
                slvCnt <= SLAVE_LAT;
            end
        end
        if (!oChipSelect_n && !oRead_n) begin
            case (oAddress)
                ADDR_CT0:    iRdData <= slvCt[127:96];
                ADDR_CT1:    iRdData <= slvCt[95:64];
                ADDR_CT2:    iRdData <= slvCt[63:32];
                ADDR_CT3:    iRdData <= slvCt[31:0];
                ADDR_STATUS: iRdData <= {31'd0, slvStatus & ~stuckStatus};
                default:     iRdData <= 32'd0;
            endcase
        end else begin
            iRdData <= 32'hDEAD_BEE0;
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        int          cyc;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } busRec_t;
    busRec_t busLog[$];

    always @(negedge iClk) begin
        if (!iReset) begin
            tests++;
            if (!oChipSelect_n) begin
                if (!(oWrite_n ^ oRead_n)) begin
                    fails++;
                    $display("FAIL bus strobes at cyc %0d: wr_n=%b rd_n=%b, need exactly one low", cyc, oWrite_n, oRead_n);
                end
                busLog.push_back('{cyc, !oWrite_n, oAddress, oWrData});
            end else if (!oWrite_n || !oRead_n || oAddress != 4'd0 || oWrData != 32'd0) begin
                fails++;
                $display("FAIL idle bus at cyc %0d: wr_n=%b rd_n=%b addr=%h data=%h, need 1 1 0 0",
                         cyc, oWrite_n, oRead_n, oAddress, oWrData);
            end
        end
    end

    // ---------------- scoreboard and helpers ----------------
    logic [127:0] ctQ[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sendCmd(input logic isKey, input logic [127:0] d, output int c0);
        int n = 0;
        @(negedge iClk);
        iCmdValid = 1'b1;
        iCmdIsKey = isKey;
        iCmdData  = d;
        while (!oCmdReady && n < 300) begin
            @(negedge iClk);
            n++;
        end
        c0 = cyc;
        tests++;
        if (!oCmdReady) begin
            fails++;
            $display("FAIL cmd accept: oCmdReady=%b after %0d cycles, expected 1", oCmdReady, n);
            iCmdValid = 1'b0;
            return;
        end
        @(posedge iClk);
        #1;
        iCmdValid = 1'b0;
        iCmdData  = '0;
    endtask

    task automatic waitResult(input int c0);
        int n = 0;
        logic [127:0] exp;
        iResReady = 1'b1;
        @(negedge iClk);
        while (!oResValid && n < 400) begin
            @(negedge iClk);
            n++;
        end
        if (!oResValid) begin
            tests++;
            fails++;
            $display("FAIL result timeout: oResValid=%b after %0d cycles, expected 1", oResValid, n);
            return;
        end
        check("result latency", cyc - c0, 16 + CT_WAIT);
        if (ctQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected result: got %h expected none", oResData);
        end else begin
            exp = ctQ.pop_front();
            check("result data", oResData, exp);
        end
        @(posedge iClk);
        #1;
    endtask

    typedef struct {
        logic         isKey;
        logic [127:0] data;
        logic [127:0] expCt;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d cycles expected far fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        int tCyc;
        int statusReads;
        int ctReads;
        int writes;
        logic [127:0] curKey;
        logic [127:0] k;
        logic [127:0] exp;

        iReset = 1'b1;
        iCmdValid = 1'b0;
        iCmdIsKey = 1'b0;
        iCmdData = '0;
        iResReady = 1'b1;
        #12;
        check("reset cs_n", oChipSelect_n, 1);
        check("reset wr_n", oWrite_n, 1);
        check("reset rd_n", oRead_n, 1);
        check("reset addr/wrdata", {oAddress, oWrData}, 0);
        check("reset ready/valid/timeout/busy", {oCmdReady, oResValid, oTimeoutErr, oBusy}, 0);
        check("reset resdata", oResData, 0);
        repeat (3) @(negedge iClk);
        iReset = 1'b0;
        @(negedge iClk);
        check("post reset strobes", {oChipSelect_n, oWrite_n, oRead_n}, 3'b111);

        // Test 1: key command write sequence and ready latency
        curKey = 128'h000102030405060708090a0b0c0d0e0f;
        busLog.delete();
        sendCmd(1'b1, curKey, c0);
        while (cyc < c0 + 5) @(negedge iClk);
        check("t1 ready low at 5", oCmdReady, 0);
        @(negedge iClk);
        check("t1 ready back at 6", oCmdReady, 1);
        repeat (2) @(negedge iClk);
        check("t1 access count", busLog.size(), 5);
        for (int i = 0; i < 5 && i < busLog.size(); i++) begin
            check("t1 access cycle", busLog[i].cyc - c0, 1 + i);
            check("t1 access is write", busLog[i].wr, 1);
            check("t1 access addr", busLog[i].addr, (i < 4) ? i : 5);
            check("t1 access data", busLog[i].data, (i < 4) ? curKey[127-32*i -: 32] : 32'd0);
        end

        // Test 3: status stuck at 0 -> timeout after POLL_MAX polls
        stuckStatus = 1'b1;
        busLog.delete();
        sendCmd(1'b0, 128'hcafef00d_12345678_9abcdef0_0badf00d, c0);
        n = 0;
        @(negedge iClk);
        while (!oTimeoutErr && n < 300) begin
            @(negedge iClk);
            n++;
        end
        tCyc = cyc;
        check("t3 timeout seen", oTimeoutErr, 1);
        check("t3 timeout cycle", tCyc - c0, 6 + CT_WAIT + 2 * POLL_MAX);
        check("t3 idle at timeout", oBusy, 0);
        @(negedge iClk);
        check("t3 timeout one cycle", oTimeoutErr, 0);
        statusReads = 0;
        ctReads = 0;
        writes = 0;
        foreach (busLog[i]) begin
            if (busLog[i].wr) writes++;
            else if (busLog[i].addr == ADDR_STATUS) statusReads++;
            else ctReads++;
        end
        check("t3 status reads", statusReads, POLL_MAX);
        check("t3 ct reads", ctReads, 0);
        check("t3 writes", writes, 5);
        stuckStatus = 1'b0;

        // Table-driven command/result stream
        vecs[0] = '{1'b0, 128'h00112233445566778899aabbccddeeff, '0};
        vecs[1] = '{1'b0, 128'hffeeddccbbaa99887766554433221100, '0};
        vecs[2] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, '0};
        vecs[3] = '{1'b0, 128'h6bc1bee22e409f96e93d7e117393172a, '0};
        vecs[4] = '{1'b0, 128'h0, '0};
        k = curKey;
        foreach (vecs[i]) begin
            if (vecs[i].isKey) k = vecs[i].data;
            else vecs[i].expCt = cipherModel(k, vecs[i].data);
        end
        foreach (vecs[i]) begin
            if (!vecs[i].isKey) ctQ.push_back(vecs[i].expCt);
            sendCmd(vecs[i].isKey, vecs[i].data, c0);
            if (!vecs[i].isKey) waitResult(c0);
        end
        curKey = k;

        // Test 4: consumer stalls; result held and second command held off
        iResReady = 1'b0;
        exp = cipherModel(curKey, 128'h3243f6a8885a308d313198a2e0370734);
        sendCmd(1'b0, 128'h3243f6a8885a308d313198a2e0370734, c0);
        n = 0;
        @(negedge iClk);
        while (!oResValid && n < 300) begin
            @(negedge iClk);
            n++;
        end
        check("t4 result data", oResData, exp);
        iCmdValid = 1'b1;
        iCmdIsKey = 1'b1;
        iCmdData  = 128'h603deb1015ca71be2b73aef0857d7781;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            check("t4 hold valid/ready/data", {oResValid, oCmdReady, oResData}, {1'b1, 1'b0, exp});
        end
        iResReady = 1'b1;
        @(negedge iClk);
        check("t4 valid drops after take", oResValid, 0);
        n = 0;
        while (!oCmdReady && n < 50) begin
            @(negedge iClk);
            n++;
        end
        check("t4 held command accepted", oCmdReady, 1);
        @(posedge iClk);
        #1;
        iCmdValid = 1'b0;
        curKey = 128'h603deb1015ca71be2b73aef0857d7781;

        // Test 5: reset during ciphertext read-back
        sendCmd(1'b0, 128'h11111111_22222222_33333333_44444444, c0);
        n = 0;
        @(negedge iClk);
        while (!(!oRead_n && oAddress == ADDR_CT1) && n < 300) begin
            @(negedge iClk);
            n++;
        end
        check("t5 reached word1 read", {oRead_n, oAddress}, {1'b0, ADDR_CT1});
        @(posedge iClk);
        @(posedge iClk);
        #2;
        iReset = 1'b1;
        #1;
        check("t5 strobes in reset", {oChipSelect_n, oWrite_n, oRead_n}, 3'b111);
        check("t5 busy/valid/ready in reset", {oBusy, oResValid, oCmdReady}, 0);
        check("t5 resdata in reset", oResData, 0);
        repeat (2) @(negedge iClk);
        iReset = 1'b0;
        @(negedge iClk);
        check("t5 no strobe after release", {oChipSelect_n, oWrite_n, oRead_n}, 3'b111);
        check("t5 ready after release", {oCmdReady, oBusy}, 2'b10);
        ctQ.push_back(cipherModel(curKey, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0));
        sendCmd(1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, c0);
        waitResult(c0);

        repeat (3) @(negedge iClk);
        check("scoreboard drained", ctQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
